// File: rtl/sedbec_serial_link.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sedbec_serial_link : SEC-DED encode, bit-serial noisy channel, decode/fix  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+

module sedbec_serial_link #(
  parameter int DATA_W     = 4,
  parameter int BIT_CYCLES = 16,
  parameter int CNT_W      = 16,
  localparam int PAR_W     = (DATA_W == 4) ? 3 : (DATA_W == 11) ? 4 : 5,
  localparam int CODE_W    = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] sedbec_in,
  input  logic [CODE_W-1:0] noise,
  input  logic              clr_cnt,
  output logic              busy,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic [DATA_W-1:0] data_o,
  output logic              error1bit,
  output logic              error2bit,
  output logic              errorparity,
  output logic              done,
  output logic [CNT_W-1:0]  cnt_corrected,
  output logic [CNT_W-1:0]  cnt_uncorrectable
);

  localparam int CYC_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int DIDX_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SHIFT  = 3'd2,
    S_DECODE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  data_q;
  logic [CODE_W-1:0]  noise_q;
  logic [CODE_W-1:0]  code_q;
  logic [CODE_W-1:0]  rx_q;
  logic [PAR_W-1:0]   pos_q;
  logic [CYC_W-1:0]   cyc_q;
  logic [DATA_W-1:0]  res_data_q;
  logic               res_e1_q, res_e2_q, res_ep_q;
  logic               done_q;

  logic               bit_end_w, last_bit_w, par_w;
  logic [PAR_W-1:0]   syn_w;
  logic [CODE_W-1:0]  fixed_w;

  // Data fills non-power-of-two positions in ascending order; parity bits then overall parity.
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    int j;
    c = '0;
    j = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[PAR_W'(p)] = d[DIDX_W'(j)];
        j++;
      end
    end
    for (int k = 0; k < PAR_W; k++) begin
      for (int p = 1; p < CODE_W; p++) begin
        if ((((p >> k) & 1) == 1) && (p != (1 << k)))
          c[PAR_W'(1 << k)] = c[PAR_W'(1 << k)] ^ c[PAR_W'(p)];
      end
    end
    c[0] = ^c[CODE_W-1:1];
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[DIDX_W'(j)] = c[PAR_W'(p)];
        j++;
      end
    end
    return d;
  endfunction

  assign bit_end_w  = (cyc_q == CYC_W'(BIT_CYCLES - 1));
  assign last_bit_w = bit_end_w && (pos_q == PAR_W'(CODE_W - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // A start seen during the done pulse is still inside the busy window and is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start && !done_q) state_d = S_LOAD;
      S_LOAD:   state_d = S_SHIFT;
      S_SHIFT:  if (last_bit_w) state_d = S_DECODE;
      S_DECODE: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign tx_valid = (state_q == S_SHIFT);
  assign tx_bit   = tx_valid & code_q[pos_q];
  assign busy     = (state_q != S_IDLE) | done_q;
  assign done     = done_q;

  // Syndrome and overall parity of the received word; CODE_W is 2^PAR_W so syn_w always indexes in range.
  always_comb begin
    syn_w = '0;
    for (int p = 1; p < CODE_W; p++) begin
      if (rx_q[PAR_W'(p)]) syn_w = syn_w ^ PAR_W'(p);
    end
    par_w   = ^rx_q;
    fixed_w = rx_q;
    if ((syn_w != '0) && par_w) fixed_w[syn_w] = ~rx_q[syn_w];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      noise_q     <= '0;
      code_q      <= '0;
      rx_q        <= '0;
      pos_q       <= '0;
      cyc_q       <= '0;
      res_data_q  <= '0;
      res_e1_q    <= 1'b0;
      res_e2_q    <= 1'b0;
      res_ep_q    <= 1'b0;
      data_o      <= '0;
      error1bit   <= 1'b0;
      error2bit   <= 1'b0;
      errorparity <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (state_d == S_LOAD) begin
            data_q  <= sedbec_in;
            noise_q <= noise;
          end
        end
        S_LOAD: begin
          code_q <= encode(data_q);
          rx_q   <= '0;
          pos_q  <= '0;
          cyc_q  <= '0;
        end
        S_SHIFT: begin
          if (bit_end_w) begin
            rx_q[pos_q] <= tx_bit ^ noise_q[pos_q];
            pos_q       <= pos_q + PAR_W'(1);
            cyc_q       <= '0;
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
        S_DECODE: begin
          res_data_q <= extract(fixed_w);
          res_e1_q   <= par_w;
          res_e2_q   <= (syn_w != '0) && !par_w;
          res_ep_q   <= (syn_w == '0) && par_w;
        end
        S_DONE: begin
          data_o      <= res_data_q;
          error1bit   <= res_e1_q;
          error2bit   <= res_e2_q;
          errorparity <= res_ep_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt_corrected     <= '0;
      cnt_uncorrectable <= '0;
    end else if (state_q == S_DONE) begin
      if (res_e1_q && (cnt_corrected != '1))
        cnt_corrected <= cnt_corrected + CNT_W'(1);
      if (res_e2_q && (cnt_uncorrectable != '1))
        cnt_uncorrectable <= cnt_uncorrectable + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sedbec_serial_link.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sedbec_serial_link : directed self-checking bench for sedbec_serial_link|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+

module tb_sedbec_serial_link;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  start;
  logic [25:0] din;
  logic [31:0] nz;
  logic        clr;

  int checks   = 0;
  int failures = 0;
  int txz_err  = 0;

  logic [3:0]  busy_v, txb_v, txv_v, done_v, e1_v, e2_v, ep_v;
  logic [25:0] dout_v [4];
  logic [15:0] cc_v   [4];
  logic [15:0] cu_v   [4];

  logic [3:0]  d0, d1;
  logic [10:0] d2;
  logic [25:0] d3;
  logic [15:0] c0c, c0u, c2c, c2u, c3c, c3u;
  logic [1:0]  c1c, c1u;

  sedbec_serial_link #(.DATA_W(4), .BIT_CYCLES(16), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .sedbec_in(din[3:0]), .noise(nz[7:0]),
    .clr_cnt(clr), .busy(busy_v[0]), .tx_bit(txb_v[0]), .tx_valid(txv_v[0]),
    .data_o(d0), .error1bit(e1_v[0]), .error2bit(e2_v[0]), .errorparity(ep_v[0]),
    .done(done_v[0]), .cnt_corrected(c0c), .cnt_uncorrectable(c0u));

  sedbec_serial_link #(.DATA_W(4), .BIT_CYCLES(1), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .sedbec_in(din[3:0]), .noise(nz[7:0]),
    .clr_cnt(clr), .busy(busy_v[1]), .tx_bit(txb_v[1]), .tx_valid(txv_v[1]),
    .data_o(d1), .error1bit(e1_v[1]), .error2bit(e2_v[1]), .errorparity(ep_v[1]),
    .done(done_v[1]), .cnt_corrected(c1c), .cnt_uncorrectable(c1u));

  sedbec_serial_link #(.DATA_W(11), .BIT_CYCLES(1), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .sedbec_in(din[10:0]), .noise(nz[15:0]),
    .clr_cnt(clr), .busy(busy_v[2]), .tx_bit(txb_v[2]), .tx_valid(txv_v[2]),
    .data_o(d2), .error1bit(e1_v[2]), .error2bit(e2_v[2]), .errorparity(ep_v[2]),
    .done(done_v[2]), .cnt_corrected(c2c), .cnt_uncorrectable(c2u));

  sedbec_serial_link #(.DATA_W(26), .BIT_CYCLES(1), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .start(start[3]), .sedbec_in(din), .noise(nz),
    .clr_cnt(clr), .busy(busy_v[3]), .tx_bit(txb_v[3]), .tx_valid(txv_v[3]),
    .data_o(d3), .error1bit(e1_v[3]), .error2bit(e2_v[3]), .errorparity(ep_v[3]),
    .done(done_v[3]), .cnt_corrected(c3c), .cnt_uncorrectable(c3u));

  assign dout_v[0] = 26'(d0);
  assign dout_v[1] = 26'(d1);
  assign dout_v[2] = 26'(d2);
  assign dout_v[3] = d3;
  assign cc_v[0] = c0c;  assign cu_v[0] = c0u;
  assign cc_v[1] = 16'(c1c); assign cu_v[1] = 16'(c1u);
  assign cc_v[2] = c2c;  assign cu_v[2] = c2u;
  assign cc_v[3] = c3c;  assign cu_v[3] = c3u;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] fl(input int u);
    return {e1_v[u], e2_v[u], ep_v[u]};
  endfunction

  // tail = {busy during done, busy next cycle, done next cycle}
  task automatic run(input int u, input logic [25:0] d, input logic [31:0] n,
                     output int lat, output int vc, output logic [31:0] bits,
                     output logic [2:0] tail);
    int bc;
    bc   = (u == 0) ? 16 : 1;
    din  = d;
    nz   = n;
    start[u] = 1'b1;
    @(posedge clk); #1;
    start[u] = 1'b0;
    lat  = 0;
    vc   = 0;
    bits = '0;
    while ((lat < 400) && !done_v[u]) begin
      @(posedge clk); #1;
      lat++;
      if (txv_v[u]) vc++;
      if (!txv_v[u] && txb_v[u]) txz_err++;
      if (txv_v[u] && (((lat - 1) % bc) == (bc / 2))) bits[((lat - 1) / bc) % 32] = txb_v[u];
    end
    chk("done_within_bound", 64'(done_v[u]), 64'd1);
    tail[2] = busy_v[u];
    @(posedge clk); #1;
    tail[1] = busy_v[u];
    tail[0] = done_v[u];
  endtask

  initial begin
    int lat, vc, nd;
    logic [31:0] bits;
    logic [2:0]  tl;
    logic [25:0] w;

    rst = 1'b1; start = '0; din = '0; nz = '0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ctrl", 64'({busy_v[0], txb_v[0], txv_v[0], done_v[0], fl(0)}), 64'd0);
    chk("reset_data", 64'(dout_v[0]), 64'd0);
    chk("reset_cnts", 64'({cc_v[0], cu_v[0]}), 64'd0);

    // Clean 1011 -> codeword pos0..7 = 0,1,0,1,0,1,0,1
    run(0, 26'hB, 32'h0, lat, vc, bits, tl);
    chk("clean_latency", 64'(lat), 64'd131);
    chk("clean_txvalid_len", 64'(vc), 64'd128);
    chk("clean_tx_bits", 64'(bits[7:0]), 64'hAA);
    chk("clean_data", 64'(dout_v[0]), 64'hB);
    chk("clean_flags", 64'(fl(0)), 64'd0);
    chk("clean_busy_done_tail", 64'(tl), 64'b100);

    run(0, 26'hB, 32'h20, lat, vc, bits, tl);
    chk("pos5_data", 64'(dout_v[0]), 64'hB);
    chk("pos5_flags", 64'(fl(0)), 64'b100);
    chk("pos5_cnt", 64'(cc_v[0]), 64'd1);

    run(0, 26'hB, 32'h01, lat, vc, bits, tl);
    chk("pos0_data", 64'(dout_v[0]), 64'hB);
    chk("pos0_flags", 64'(fl(0)), 64'b101);
    chk("pos0_cnt", 64'(cc_v[0]), 64'd2);

    // pos3 and pos6 flipped: received data d3..d0 = 1,1,1,0
    run(0, 26'hB, 32'h48, lat, vc, bits, tl);
    chk("dbl_data", 64'(dout_v[0]), 64'hE);
    chk("dbl_flags", 64'(fl(0)), 64'b010);
    chk("dbl_cnt_unc", 64'(cu_v[0]), 64'd1);
    chk("dbl_cnt_corr", 64'(cc_v[0]), 64'd2);

    clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
    chk("clr_cnts", 64'({cc_v[0], cu_v[0]}), 64'd0);

    for (int d = 0; d < 16; d++) begin
      for (int p = 0; p < 8; p++) begin
        run(0, 26'(d), 32'(1) << p, lat, vc, bits, tl);
        chk("sweep4_data", 64'(dout_v[0]), 64'(d));
        chk("sweep4_flags", 64'(fl(0)), 64'({1'b1, 1'b0, p == 0}));
      end
    end
    chk("sweep4_cnt", 64'(cc_v[0]), 64'd128);

    clr = 1'b1;
    run(0, 26'h5, 32'h2, lat, vc, bits, tl);
    clr = 1'b0;
    chk("clr_overrides_inc", 64'(cc_v[0]), 64'd0);

    // Second start mid-transfer must not disturb the first
    din = 26'h6; nz = 32'h4; start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    lat = 0;
    repeat (20) begin @(posedge clk); #1 lat++; end
    din = 26'h9; nz = 32'h0; start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0; lat++;
    while ((lat < 400) && !done_v[0]) begin @(posedge clk); #1 lat++; end
    chk("busy_start_latency", 64'(lat), 64'd131);
    chk("busy_start_data", 64'(dout_v[0]), 64'h6);
    chk("busy_start_flags", 64'(fl(0)), 64'b100);
    nd = 0;
    repeat (150) begin @(posedge clk); #1 if (done_v[0]) nd++; end
    chk("busy_start_no_extra_done", 64'(nd), 64'd0);

    // Reset during SHIFT
    din = 26'h3; nz = 32'h0; start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (40) @(posedge clk);
    #1 chk("mid_shift_txvalid", 64'(txv_v[0]), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_txvalid", 64'(txv_v[0]), 64'd0);
    chk("rst_busy", 64'(busy_v[0]), 64'd0);
    chk("rst_data", 64'(dout_v[0]), 64'd0);
    chk("rst_cnt", 64'(cc_v[0]), 64'd0);
    nd = 0;
    repeat (150) begin @(posedge clk); #1 if (done_v[0]) nd++; end
    chk("rst_no_done", 64'(nd), 64'd0);

    run(0, 26'hB, 32'h0, lat, vc, bits, tl);
    chk("post_rst_latency", 64'(lat), 64'd131);
    chk("post_rst_data", 64'(dout_v[0]), 64'hB);
    chk("post_rst_flags", 64'(fl(0)), 64'd0);

    // One bit per clock, 2-bit counters
    run(1, 26'hB, 32'h0, lat, vc, bits, tl);
    chk("bc1_latency", 64'(lat), 64'd11);
    chk("bc1_txvalid_len", 64'(vc), 64'd8);
    chk("bc1_tx_bits", 64'(bits[7:0]), 64'hAA);
    chk("bc1_data", 64'(dout_v[1]), 64'hB);
    for (int i = 0; i < 5; i++) begin
      run(1, 26'h9, 32'(1) << i, lat, vc, bits, tl);
      chk("bc1_data_corr", 64'(dout_v[1]), 64'h9);
      if (i == 2) chk("sat_cnt_3", 64'(cc_v[1]), 64'd3);
    end
    chk("sat_cnt_hold", 64'(cc_v[1]), 64'd3);

    for (int k = 0; k < 3; k++) begin
      w = 26'($urandom) & 26'h7FF;
      run(2, w, 32'h0, lat, vc, bits, tl);
      chk("w11_clean_data", 64'(dout_v[2]), 64'(w));
      chk("w11_clean_flags", 64'(fl(2)), 64'd0);
      for (int p = 0; p < 16; p++) begin
        run(2, w, 32'(1) << p, lat, vc, bits, tl);
        chk("w11_data", 64'(dout_v[2]), 64'(w));
        chk("w11_flags", 64'(fl(2)), 64'({1'b1, 1'b0, p == 0}));
      end
    end

    for (int k = 0; k < 3; k++) begin
      w = 26'($urandom);
      run(3, w, 32'h0, lat, vc, bits, tl);
      chk("w26_clean_data", 64'(dout_v[3]), 64'(w));
      chk("w26_clean_flags", 64'(fl(3)), 64'd0);
      for (int p = 0; p < 32; p++) begin
        run(3, w, 32'(1) << p, lat, vc, bits, tl);
        chk("w26_data", 64'(dout_v[3]), 64'(w));
        chk("w26_flags", 64'(fl(3)), 64'({1'b1, 1'b0, p == 0}));
      end
    end

    chk("tx_bit_zero_when_idle", 64'(txz_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sedbec_serial_link.md
# sedbec_serial_link

Parametrised SEC-DED link stage for the ASK communication chain: encodes a DATA_W-bit word into an extended Hamming codeword and serialises it bit by bit toward the ASK modulator. A per-bit noise mask is applied and the stream is deserialised, syndrome-decoded and corrected. It succeeds the fixed 4-bit codec by adding width generalisation, a serial channel interface with programmable bit period, and saturating error statistics.

## Interface
- DATA_W, 4, data word width; legal values 4, 11, 26 (perfect Hamming sizes)
- BIT_CYCLES, 16, clocks per channel bit; ≥1
- CNT_W, 16, width of each error counter
- Derived: PAR_W = 3/4/5 for DATA_W = 4/11/26; CODE_W = DATA_W+PAR_W+1
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- sedbec_in  in  DATA_W  payload, captured when start accepted
- noise  in  CODE_W  error mask, captured with payload; bit k flips codeword position k
- clr_cnt  in  1  synchronous clear of both counters
- busy  out  1  high from accepted start through the done cycle
- tx_bit  out  1  current channel bit toward the modulator
- tx_valid  out  1  high while tx_bit is meaningful
- data_o  out  DATA_W  decoded (corrected) word
- error1bit  out  1  single-bit error corrected
- error2bit  out  1  uncorrectable double error
- errorparity  out  1  the single error was in the overall parity bit
- done  out  1  one-cycle pulse; result outputs valid
- cnt_corrected  out  CNT_W  count of error1bit results
- cnt_uncorrectable  out  CNT_W  count of error2bit results

## Operation
- Codeword layout: position 0 = overall parity; positions 1..CODE_W-1 Hamming; powers of two are parity bits, other positions carry data bits in ascending data index (pos3=d0, pos5=d1, ...).
- Parity p(2^k) = XOR of all positions 1..CODE_W-1 with bit k set; position 0 = XOR of positions 1..CODE_W-1.
- FSM: IDLE → LOAD (encode, latch noise) → SHIFT (CODE_W × BIT_CYCLES clocks) → DECODE → DONE → IDLE.
- SHIFT: positions transmitted 0 first; tx_bit held BIT_CYCLES clocks per bit; on the last clock of each bit period, rx shift register captures tx_bit ^ noise[pos].
- DECODE: syndrome s = XOR of indices of received 1-bits in positions 1..CODE_W-1; g = XOR of all received bits.
  - s=0, g=0: clean; all flags 0.
  - s≠0, g=1: flip position s; error1bit=1.
  - s=0, g=1: data unchanged; error1bit=1, errorparity=1.
  - s≠0, g=0: error2bit=1; data_o = uncorrected received data bits.
- data_o and flags register in DONE and hold until the next DONE.
- Counters increment in DONE on error1bit / error2bit; saturate at all-ones; clr_cnt overrides a same-cycle increment.
- start while busy ignored; start still high in IDLE after DONE begins a new transaction.

## Timing
- Reset: state IDLE; busy, tx_bit, tx_valid, done, data_o, all flags, both counters = 0.
- start sampled at edge E0 → busy=1 after E0; tx_valid=1 for exactly CODE_W×BIT_CYCLES clocks starting after E0+1.
- done high for exactly one clock, asserted CODE_W×BIT_CYCLES+3 clocks after E0 (DATA_W=4, BIT_CYCLES=16: 131).
- busy falls the clock after done.
- tx_bit = 0 whenever tx_valid = 0.
- rst mid-transaction: IDLE next clock; no done; captured results and counters cleared.
- BIT_CYCLES=1: one bit per clock, no gap between bits.

## Test plan
- DATA_W=4, sedbec_in=4'b1011, noise=0 → tx_bit sequence 0,1,0,1,0,1,0,1 (16 clocks each); data_o=1011, flags 0, done at clock 131.
- sedbec_in=4'b1011, noise=8'b0010_0000 (pos 5) → data_o=1011, error1bit=1, errorparity=0, cnt_corrected=1.
- noise=8'b0000_0001 (pos 0) → data_o correct, error1bit=1, errorparity=1.
- noise=8'b0100_1000 (pos 3,6) → error2bit=1, error1bit=0, cnt_uncorrectable=1.
- All 16 data × 8 single-bit masks → all corrected, cnt_corrected=128; clr_cnt → 0; CNT_W=2 build saturates at 3; repeat exhaustive single-bit sweep on random words with DATA_W=11 and 26.
- rst pulsed mid-SHIFT → tx_valid 0 next clock, no done; start pulsed while busy ignored; following transaction completes normally.
